// File: rtl/ifetch_icache_pkg.sv
// Shared fetch-stage definitions: bus widths, cache geometry defaults and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_icache_pkg;

  localparam int ADDR_W           = 32;
  localparam int INSTR_W          = 32;
  localparam int INSTR_BYTES_W    = 2;
  localparam int ICACHE_IDX_W_DEF = 4;
  localparam int ICACHE_TAG_W_DEF = ADDR_W - ICACHE_IDX_W_DEF - 2;

  // Allocator length field is bytes-1; a full instruction word is 4 bytes.
  localparam logic [INSTR_BYTES_W-1:0] IF_OFFSET_WORD = 2'd3;

  typedef enum logic [1:0] {
    FETCH_IDLE      = 2'd0,
    FETCH_WAIT_GR   = 2'd1,
    FETCH_WAIT_DATA = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_icache_array.sv
// Direct-mapped, one-word-per-line instruction storage: valid, tag and data arrays.
// Latency: read is combinational; write lands at the clock edge.
// Backpressure: none; caller gates i_wr_en.
// Ports: i_clk, i_rst_n (sync valid clear), i_rd_idx/i_rd_tag -> o_rd_hit/o_rd_word,
//        i_wr_en/i_wr_idx/i_wr_tag/i_wr_word (synchronous fill).
module ifetch_icache_array #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_rd_hit,
  output logic [31:0]      o_rd_word,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_word
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Only the valid bits need clearing; stale tag/data behind a 0 valid bit is harmless.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_word;
    end
  end

  assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_word = r_data[i_rd_idx];

endmodule

// File: rtl/ifetch_icache.sv
// Instruction fetch: PC, direct-mapped I-cache lookup, allocator miss handshake.
// Latency: hit delivered 1 cycle after the edge that sees it; miss = allocator latency + 1.
// Backpressure: stall_in holds delivery in IDLE (fills still complete); rdy_in=0 freezes everything.
// Ports: clk_in/rst_in, rdy_in, clear_branch_in/branch_pc_in (redirect), stall_in,
//        if_valid_out/if_instr_out/if_pc_out (to decode), if_to_alloc_en_out/if_a_out/
//        if_offset_out (request), alloc_to_if_gr_in/alloc_to_if_en_in/if_d_in (response).
module ifetch_icache
  import ifetch_icache_pkg::*;
#(
  parameter int          ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_branch_in,
  input  logic [ADDR_W-1:0]        branch_pc_in,
  input  logic                     stall_in,
  output logic                     if_valid_out,
  output logic [INSTR_W-1:0]       if_instr_out,
  output logic [ADDR_W-1:0]        if_pc_out,
  output logic                     if_to_alloc_en_out,
  output logic [ADDR_W-1:0]        if_a_out,
  output logic [INSTR_BYTES_W-1:0] if_offset_out,
  input  logic                     alloc_to_if_gr_in,
  input  logic                     alloc_to_if_en_in,
  input  logic [INSTR_W-1:0]       if_d_in
);

  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  fetch_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic                r_vld, w_vld_nxt;
  logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]   r_pco, w_pco_nxt;
  logic                r_en, w_en_nxt;
  logic [ADDR_W-1:0]   r_a, w_a_nxt;
  logic                w_fill;

  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic [INSTR_W-1:0]      w_word;

  // PC does not move while a miss is outstanding, so the fill reuses the lookup index/tag.
  assign w_idx = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag = r_pc[ADDR_W-1:ICACHE_IDX_W+2];

  ifetch_icache_array #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_rd_idx  (w_idx),
    .i_rd_tag  (w_tag),
    .o_rd_hit  (w_hit),
    .o_rd_word (w_word),
    .i_wr_en   (w_fill && rdy_in && rst_in),
    .i_wr_idx  (w_idx),
    .i_wr_tag  (w_tag),
    .i_wr_word (if_d_in)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vld_nxt   = 1'b0;
    w_instr_nxt = r_instr;
    w_pco_nxt   = r_pco;
    w_en_nxt    = r_en;
    w_a_nxt     = r_a;
    w_fill      = 1'b0;
    // Redirect wins over everything, including a coincident grant or data pulse.
    if (clear_branch_in) begin
      w_pc_nxt    = branch_pc_in;
      w_state_nxt = FETCH_IDLE;
      w_en_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          if (!stall_in) begin
            if (w_hit) begin
              w_vld_nxt   = 1'b1;
              w_instr_nxt = w_word;
              w_pco_nxt   = r_pc;
              w_pc_nxt    = r_pc + 32'd4;
            end else begin
              w_en_nxt    = 1'b1;
              w_a_nxt     = r_pc;
              w_state_nxt = FETCH_WAIT_GR;
            end
          end
        end
        FETCH_WAIT_GR: begin
          // Request drops on the grant cycle itself so it is never granted twice.
          if (alloc_to_if_gr_in) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = FETCH_WAIT_DATA;
          end
        end
        FETCH_WAIT_DATA: begin
          if (alloc_to_if_en_in) begin
            w_fill      = 1'b1;
            w_state_nxt = FETCH_IDLE;
          end
        end
        default: w_state_nxt = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_vld   <= 1'b0;
      r_instr <= '0;
      r_pco   <= '0;
      r_en    <= 1'b0;
      r_a     <= '0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_vld   <= w_vld_nxt;
      r_instr <= w_instr_nxt;
      r_pco   <= w_pco_nxt;
      r_en    <= w_en_nxt;
      r_a     <= w_a_nxt;
    end
  end

  assign if_valid_out       = r_vld;
  assign if_instr_out       = r_instr;
  assign if_pc_out          = r_pco;
  assign if_to_alloc_en_out = r_en;
  assign if_a_out           = r_a;
  assign if_offset_out      = IF_OFFSET_WORD;

endmodule
